reg_seq_ctrl: RTL

// Command sequencer that drives the 4-entry, 9-bit register file's write

---
 rtl/reg_seq_pkg.sv | 28 ++
 rtl/reg_seq_alu.sv | 37 +++
 rtl/reg_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/reg_seq_pkg.sv
// rtl/reg_seq_pkg.sv - shared types, defaults and index check for the register sequencer
package reg_seq_pkg;

  localparam int DEF_DATA_W   = 9;
  localparam int DEF_IDX_W    = 3;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MOV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_CAP_A = 3'd2,
    S_CAP_B = 3'd3,
    S_WB    = 3'd4
  } state_e;

  // Register 0 is reserved; valid indices are 1..num_regs.
  function automatic logic idx_legal(input int idx, input int num_regs);
    return (idx >= 1) && (idx <= num_regs);
  endfunction

endpackage

// File: rtl/reg_seq_alu.sv
// rtl/reg_seq_alu.sv - unsigned add/sub/pass-through with carry/borrow flag
module reg_seq_alu
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum = '0;
    y     = '0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        y     = w_sum[DATA_W-1:0];
        ovf   = w_sum[DATA_W];
      end
      OP_SUB: begin
        y   = a - b;
        ovf = (a < b);
      end
      default: begin
        y   = a;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// rtl/reg_seq_ctrl.sv - command sequencer driving the register file read and write ports
module reg_seq_ctrl
  import reg_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_src_a,
  input  logic [IDX_W-1:0]  cmd_src_b,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_write,
  output logic [IDX_W-1:0]  rf_reg_num,
  output logic [DATA_W-1:0] rf_op,
  output logic [IDX_W-1:0]  rf_reg_sel,
  input  logic [DATA_W-1:0] rf_reg_val,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [DATA_W-1:0] result
);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [IDX_W-1:0]  r_src_a;
  logic [IDX_W-1:0]  r_src_b;
  logic [IDX_W-1:0]  r_dst;
  logic              r_err;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_result;
  logic              r_ovf;

  op_e               w_cmd_op;
  logic              w_accept;
  logic              w_need_a;
  logic              w_need_b;
  logic              w_illegal;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_ovf;

  assign w_cmd_op = op_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_need_a = (w_cmd_op != OP_LOAD);
  assign w_need_b = (w_cmd_op == OP_ADD) || (w_cmd_op == OP_SUB);

  assign w_illegal = !idx_legal(int'(cmd_dst), NUM_REGS) ||
                     (w_need_a && !idx_legal(int'(cmd_src_a), NUM_REGS)) ||
                     (w_need_b && !idx_legal(int'(cmd_src_b), NUM_REGS));

  // Second operand comes straight off the read port during CAP_B.
  reg_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a   (r_op_a),
    .b   (rf_reg_val),
    .op  (r_op),
    .y   (w_alu_y),
    .ovf (w_alu_ovf)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    rf_reg_sel = '0;
    rf_write   = 1'b0;
    rf_reg_num = '0;
    rf_op      = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = (w_cmd_op == OP_LOAD || w_illegal) ? S_WB : S_RD_A;
        end
      end
      S_RD_A: begin
        rf_reg_sel = r_src_a;
        w_next     = S_CAP_A;
      end
      S_CAP_A: begin
        if (r_op == OP_MOV) begin
          w_next = S_WB;
        end else begin
          rf_reg_sel = r_src_b;
          w_next     = S_CAP_B;
        end
      end
      S_CAP_B: begin
        w_next = S_WB;
      end
      S_WB: begin
        rf_write   = ~r_err;
        rf_reg_num = r_dst;
        rf_op      = r_result;
        done       = 1'b1;
        err        = r_err;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // An illegal command leaves result/ovf untouched so the previous outcome stays visible.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_op     <= OP_LOAD;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_err    <= 1'b0;
      r_op_a   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_cmd_op;
        r_src_a <= cmd_src_a;
        r_src_b <= cmd_src_b;
        r_dst   <= cmd_dst;
        r_err   <= w_illegal;
        if (w_cmd_op == OP_LOAD && !w_illegal) begin
          r_result <= cmd_imm;
          r_ovf    <= 1'b0;
        end
      end
      if (r_state == S_CAP_A) begin
        r_op_a <= rf_reg_val;
        if (r_op == OP_MOV) begin
          r_result <= rf_reg_val;
          r_ovf    <= 1'b0;
        end
      end
      if (r_state == S_CAP_B) begin
        r_result <= w_alu_y;
        r_ovf    <= w_alu_ovf;
      end
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;

endmodule
